// File: rtl/stopwatch_counter.sv
// stopwatch_counter
//   Elapsed-time datapath that sits behind the stopwatch control FSM. It divides
//   clk into count ticks and keeps a 4-digit BCD count from 0000 to 9999. Each
//   tick adds 1 in one-run mode and 10 in ten-run mode.
//
// Parameters
//   CLK_DIV       clk cycles per count tick (>= 1)
//
// Ports
//   clk           system clock; all state changes on the rising edge
//   rst           synchronous, active-high reset
//   clear_push    FSM is in CLEAR  : zero the count and the prescaler
//   one_run_push  FSM is in ONERUN : count by 1 on each tick
//   ten_run_push  FSM is in TENRUN : count by 10 on each tick
//   pause_push    FSM is in PAUSE  : hold everything
//   digit0..3     BCD units / tens / hundreds / thousands (registered)
//   running       registered; high when a run mode was applied on the last edge
//   wrap          registered one-cycle pulse when the count passes 9999
//
// Mode priority when several inputs are high: clear > pause > ten > one.
// When no input is high, the block behaves as in pause.
module stopwatch_counter #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_push,
  input  logic       one_run_push,
  input  logic       ten_run_push,
  input  logic       pause_push,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic       running,
  output logic       wrap
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0]     pre_cnt;
  logic [3:0][3:0]   cnt;
  logic [3:0][3:0]   step_cnt;
  logic              step_wrap;

  logic mode_clear;
  logic mode_ten;
  logic mode_run;

  // Priority decode. Pause and idle both fall through to "not running".
  assign mode_clear = clear_push;
  assign mode_ten   = !clear_push && !pause_push && ten_run_push;
  assign mode_run   = !clear_push && !pause_push && (ten_run_push || one_run_push);

  // BCD ripple increment. The carry is injected at digit0 for one-run and at
  // digit1 for ten-run, so digit0 does not change in ten-run mode.
  always_comb begin
    logic c;
    logic cin;
    step_cnt = cnt;
    c        = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cin = c || ((i == 0) && !mode_ten) || ((i == 1) && mode_ten);
      if (cin) begin
        if (cnt[i] == 4'd9) begin
          step_cnt[i] = 4'd0;
          c           = 1'b1;
        end else begin
          step_cnt[i] = cnt[i] + 4'd1;
          c           = 1'b0;
        end
      end else begin
        c = 1'b0;
      end
    end
    step_wrap = c;
  end

  always_ff @(posedge clk) begin
    if (rst || mode_clear) begin
      cnt     <= '0;
      pre_cnt <= '0;
      running <= 1'b0;
      wrap    <= 1'b0;
    end else if (mode_run) begin
      running <= 1'b1;
      if (pre_cnt == PRE_LAST) begin
        pre_cnt <= '0;
        cnt     <= step_cnt;
        wrap    <= step_wrap;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
        wrap    <= 1'b0;
      end
    end else begin
      running <= 1'b0;
      wrap    <= 1'b0;
    end
  end

  assign digit0 = cnt[0];
  assign digit1 = cnt[1];
  assign digit2 = cnt[2];
  assign digit3 = cnt[3];

endmodule

// File: tb/tb_stopwatch_counter.sv
// Testbench for stopwatch_counter (CLK_DIV = 4).
// A directed vector table, hand-written corner sequences and a randomized phase
// all run against an integer reference model of the elapsed count.
module tb_stopwatch_counter;

  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear_push = 1'b0;
  logic       one_run_push = 1'b0;
  logic       ten_run_push = 1'b0;
  logic       pause_push = 1'b0;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic       running, wrap;
  logic [15:0] dut_digits;

  assign dut_digits = {digit3, digit2, digit1, digit0};

  stopwatch_counter #(.CLK_DIV(CLK_DIV)) dut (
    .clk          (clk),
    .rst          (rst),
    .clear_push   (clear_push),
    .one_run_push (one_run_push),
    .ten_run_push (ten_run_push),
    .pause_push   (pause_push),
    .digit0       (digit0),
    .digit1       (digit1),
    .digit2       (digit2),
    .digit3       (digit3),
    .running      (running),
    .wrap         (wrap)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: elapsed count as a plain integer
  int m_count = 0;
  int m_pre   = 0;
  bit m_run   = 1'b0;
  bit m_wrap  = 1'b0;

  typedef struct {
    bit r, c, o, t, p;
    int n;
    int cnt;
    bit run;
    bit wr;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(bit r, bit c, bit o, bit t, bit p, int n, int cnt, bit run, bit wr);
    vec_t v;
    v.r = r; v.c = c; v.o = o; v.t = t; v.p = p;
    v.n = n; v.cnt = cnt; v.run = run; v.wr = wr;
    return v;
  endfunction

  function automatic logic [15:0] to_bcd(int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one clock with the given inputs, advance the model, compare everything.
  task automatic cycle(input bit r, input bit c, input bit o, input bit t, input bit p);
    rst = r; clear_push = c; one_run_push = o; ten_run_push = t; pause_push = p;
    @(posedge clk);
    if (r || c) begin
      m_count = 0; m_pre = 0; m_run = 1'b0; m_wrap = 1'b0;
    end else if (p || !(o || t)) begin
      m_run = 1'b0; m_wrap = 1'b0;
    end else begin
      m_run  = 1'b1;
      m_wrap = 1'b0;
      if (m_pre == CLK_DIV - 1) begin
        m_pre   = 0;
        m_count = m_count + (t ? 10 : 1);
        if (m_count > 9999) begin
          m_count = m_count - 10000;
          m_wrap  = 1'b1;
        end
      end else begin
        m_pre++;
      end
    end
    #1;
    check("model_digits", dut_digits, to_bcd(m_count));
    check("model_running", {15'd0, running}, {15'd0, m_run});
    check("model_wrap", {15'd0, wrap}, {15'd0, m_wrap});
  endtask

  // mode: 0 idle, 1 one-run, 2 ten-run, 3 pause, 4 clear
  task automatic run_n(input int mode, input int n);
    for (int i = 0; i < n; i++)
      cycle(1'b0, mode == 4, mode == 1, mode == 2, mode == 3);
  endtask

  task automatic expect_state(input string name, input int cnt, input bit run, input bit wr);
    check({name, "_digits"}, dut_digits, to_bcd(cnt));
    check({name, "_running"}, {15'd0, running}, {15'd0, run});
    check({name, "_wrap"}, {15'd0, wrap}, {15'd0, wr});
  endtask

  initial begin
    //            r  c  o  t  p   n  cnt run wr
    tbl[0]  = mk(1, 0, 1, 0, 0,  2,  0, 0, 0);  // reset beats one-run
    tbl[1]  = mk(1, 1, 0, 0, 0,  2,  0, 0, 0);  // reset with clear
    tbl[2]  = mk(0, 0, 1, 0, 0,  1,  0, 1, 0);  // running from edge 1
    tbl[3]  = mk(0, 0, 1, 0, 0,  3,  1, 1, 0);  // first tick at edge 4
    tbl[4]  = mk(0, 0, 1, 0, 0,  4,  2, 1, 0);  // edge 8
    tbl[5]  = mk(0, 0, 1, 0, 0,  4,  3, 1, 0);  // edge 12
    tbl[6]  = mk(0, 0, 1, 0, 0,  2,  3, 1, 0);  // partial period, pre=2
    tbl[7]  = mk(0, 0, 0, 0, 1, 10,  3, 0, 0);  // pause holds
    tbl[8]  = mk(0, 0, 1, 0, 0,  1,  3, 1, 0);  // resume: pre=3
    tbl[9]  = mk(0, 0, 1, 0, 0,  1,  4, 1, 0);  // tick on second resumed edge
    tbl[10] = mk(0, 0, 0, 0, 0,  3,  4, 0, 0);  // idle holds
    tbl[11] = mk(0, 0, 0, 1, 1,  2,  4, 0, 0);  // pause beats ten
    tbl[12] = mk(0, 1, 1, 0, 0,  1,  0, 0, 0);  // clear beats one

    for (int k = 0; k < 13; k++) begin
      for (int j = 0; j < tbl[k].n; j++)
        cycle(tbl[k].r, tbl[k].c, tbl[k].o, tbl[k].t, tbl[k].p);
      expect_state($sformatf("tbl%0d", k), tbl[k].cnt, tbl[k].run, tbl[k].wr);
    end

    // Clear at 0042 with one-run also high; pre_cnt must restart from 0
    run_n(1, 42 * CLK_DIV + 2);
    expect_state("pre42", 42, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_state("clr42", 0, 1'b0, 1'b0);
    run_n(1, CLK_DIV - 1);
    expect_state("clr42_pre", 0, 1'b1, 1'b0);
    run_n(1, 1);
    expect_state("clr42_tick", 1, 1'b1, 1'b0);

    // Mode switch mid-period: the tick uses the ten-run step
    run_n(4, 1);
    run_n(1, 2);
    run_n(2, 2);
    expect_state("switch", 10, 1'b1, 1'b0);

    // Ten-run carry: 0095 + 10 -> 0105
    run_n(4, 1);
    run_n(1, 95 * CLK_DIV);
    expect_state("pre95", 95, 1'b1, 1'b0);
    run_n(2, CLK_DIV);
    expect_state("ten105", 105, 1'b1, 1'b0);
    check("digit0_kept", {12'd0, digit0}, 16'd5);

    // 9999 + 1 wraps with a single-cycle pulse
    run_n(4, 1);
    run_n(2, 999 * CLK_DIV);
    expect_state("at9990", 9990, 1'b1, 1'b0);
    run_n(1, 9 * CLK_DIV);
    expect_state("at9999", 9999, 1'b1, 1'b0);
    run_n(1, CLK_DIV);
    expect_state("wrap1", 0, 1'b1, 1'b1);
    run_n(1, 1);
    expect_state("wrap1_end", 0, 1'b1, 1'b0);

    // 9990 + 10 -> 0000 with wrap
    run_n(4, 1);
    run_n(2, 999 * CLK_DIV);
    run_n(2, CLK_DIV);
    expect_state("wrap10a", 0, 1'b1, 1'b1);

    // 9995 + 10 -> 0005 with wrap
    run_n(4, 1);
    run_n(2, 999 * CLK_DIV);
    run_n(1, 5 * CLK_DIV);
    expect_state("at9995", 9995, 1'b1, 1'b0);
    run_n(2, CLK_DIV);
    expect_state("wrap10b", 5, 1'b1, 1'b1);
    run_n(3, 1);
    expect_state("wrap10b_end", 5, 1'b0, 1'b0);

    // Randomized phase: mostly run modes, occasional pause/idle/clear/reset
    for (int i = 0; i < 4000; i++) begin
      int sel;
      bit r, c, o, t, p;
      sel = $urandom_range(0, 99);
      r = (sel == 0);
      c = (sel == 1);
      o = 1'b0; t = 1'b0; p = 1'b0;
      if (sel >= 2 && sel < 50) o = 1'b1;
      else if (sel >= 50 && sel < 85) t = 1'b1;
      else if (sel >= 85 && sel < 93) p = 1'b1;
      else if (sel >= 93 && sel < 97) begin
        o = 1'($urandom); t = 1'($urandom); p = 1'($urandom); c = 1'($urandom);
      end
      cycle(r, c, o, t, p);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
- Datapath stage directly downstream of the stopwatch control FSM.
- Consumes the FSM's one-hot mode outputs (clear / one-run / ten-run / pause).
- Prescales the system clock into count ticks and keeps a 4-digit BCD elapsed count (0000-9999).
- In one-run mode each tick adds 1; in ten-run mode each tick adds 10. Digits feed the display driver.

Parameters:
- CLK_DIV, 4, clk cycles per count tick; legal range >= 1; CLK_DIV=1 means a tick every running cycle.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- clear_push  input  1  FSM in CLEAR state
- one_run_push  input  1  FSM in ONERUN state
- ten_run_push  input  1  FSM in TENRUN state
- pause_push  input  1  FSM in PAUSE state
- digit0  output  4  BCD units
- digit1  output  4  BCD tens
- digit2  output  4  BCD hundreds
- digit3  output  4  BCD thousands
- running  output  1  registered; 1 while a run mode was applied last cycle
- wrap  output  1  one-cycle pulse when count wraps past 9999

Behaviour:
- Internal prescaler pre_cnt, width max(1, clog2(CLK_DIV)); counts 0..CLK_DIV-1.
- rst=1 at a rising edge: digits=0, pre_cnt=0, running=0, wrap=0. Reset overrides all mode inputs, including mid-count.
- Mode priority when more than one input is high (illegal from the FSM, but defined): clear > pause > ten > one.
- No input high: same as pause.
- Clear: digits=0, pre_cnt=0, running=0, wrap=0.
- Pause / idle: digits and pre_cnt hold; running=0; wrap=0.
- Run (one or ten), applied each clock:
  - running=1.
  - If pre_cnt != CLK_DIV-1: pre_cnt+1; digits hold; wrap=0.
  - If pre_cnt == CLK_DIV-1: this is a tick. pre_cnt=0 and the step is applied to the digits in the same edge.
- Step arithmetic (BCD, ripple carry):
  - One mode adds 1 at digit0. Ten mode adds 1 at digit1; digit0 is unchanged.
  - A digit at 9 receiving a carry goes to 0 and carries on.
  - A carry out of digit3 wraps the count and sets wrap=1 for exactly that cycle.
  - Examples: 9999+1 -> 0000 with wrap; 9990+10 -> 0000 with wrap; 9995+10 -> 0005 with wrap; 0099+1 -> 0100, no wrap.
- Latency: from the first run cycle with pre_cnt=0, the first increment is visible after exactly CLK_DIV rising edges.
- Mode switch one<->ten without pause: pre_cnt continues uninterrupted; the tick uses the step of the mode present on the tick cycle.
- Pause then resume: pre_cnt is preserved, so the remaining partial period counts toward the next tick.
- Digits are always valid BCD (each 0-9); no non-BCD value is reachable from reset.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset: rst=1 for 2 cycles, with one_run_push=1 and then with clear_push=1 -> all digits 0, running=0, wrap=0; rst overrides the run input.
- One-run latency (CLK_DIV=4): one_run_push=1 for 12 cycles -> count 0001 after edge 4, 0002 after edge 8, 0003 after edge 12; running=1 from edge 1.
- Ten-run and carry: preload count to 0095 via one-run, then ten_run_push for one tick -> 0105; digit0 stays 5.
- Pause/resume (CLK_DIV=4): run 2 cycles, pause 10 cycles (count and pre_cnt hold), run 2 more cycles -> 0001 appears after the second resumed edge.
- Wrap: drive count to 9999, one-run tick -> 0000 and a single-cycle wrap=1; repeat from 9995 in ten-run -> 0005 and wrap=1.
- Priority and clear: clear_push and one_run_push both high at count 0042 -> 0000, pre_cnt=0; pause_push and ten_run_push both high -> hold; all inputs low -> hold.
